// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with iterative shift-add multiplier.
// Optional build feature: define ALU_SEQ_DIV_EN to add iterative DIVU/REMU
// (restoring division); without it opcodes 1101/1110 are reported as illegal.
// One operation in flight: IDLE accepts, CALC iterates, DONE holds the result.
module alu_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALUop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero,
  output logic                  Illegal
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t                state_r, state_nxt_s;
  logic [CW-1:0]         cnt_r;
  logic [3:0]            op_r;
  logic [DATA_WIDTH-1:0] acc_r, opa_r, opb_r;
  logic [DATA_WIDTH-1:0] result_r;
  logic                  ovf_r, cry_r, zero_r, ill_r;

  logic                   accept_s;
  logic [DATA_WIDTH:0]    add_s, sub_s;
  logic                   add_ovf_s, sub_ovf_s;
  logic [SHAMT_WIDTH-1:0] shamt_s;
  logic [DATA_WIDTH-1:0]  res_s;
  logic                   ovf_s, cry_s, ill_s, multi_s;
  logic [DATA_WIDTH-1:0]  it_acc_s, it_a_s, it_b_s, fin_res_s;

  assign accept_s  = in_valid && (state_r == IDLE);
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign Result    = result_r;
  assign Overflow  = ovf_r;
  assign CarryOut  = cry_r;
  assign Zero      = zero_r;
  assign Illegal   = ill_r;

  // Shared adder/subtractor; SUB carry-out of 1 means no borrow.
  assign add_s     = {1'b0, A} + {1'b0, B};
  assign sub_s     = {1'b0, A} + {1'b0, ~B} + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign add_ovf_s = (A[DATA_WIDTH-1] == B[DATA_WIDTH-1]) && (add_s[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
  assign sub_ovf_s = (A[DATA_WIDTH-1] != B[DATA_WIDTH-1]) && (sub_s[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
  assign shamt_s   = B[SHAMT_WIDTH-1:0];

`ifdef ALU_SEQ_DIV_EN
  logic [DATA_WIDTH:0] rem_sh_s, diff_s;
  assign rem_sh_s = {acc_r, opa_r[DATA_WIDTH-1]};
  assign diff_s   = rem_sh_s - {1'b0, opb_r};
`endif

  // Single-cycle result/flags and classification of the incoming opcode.
  always_comb begin
    res_s   = '0;
    ovf_s   = 1'b0;
    cry_s   = 1'b0;
    ill_s   = 1'b0;
    multi_s = 1'b0;
    case (ALUop)
      4'b0000: res_s = A & B;
      4'b0001: res_s = A | B;
      4'b0010: begin res_s = add_s[DATA_WIDTH-1:0]; cry_s = add_s[DATA_WIDTH]; ovf_s = add_ovf_s; end
      4'b0011: res_s = A ^ B;
      4'b0100: res_s = ~(A | B);
      4'b0101: res_s = {{(DATA_WIDTH-1){1'b0}}, (A < B)};
      4'b0110: begin res_s = sub_s[DATA_WIDTH-1:0]; cry_s = sub_s[DATA_WIDTH]; ovf_s = sub_ovf_s; end
      4'b0111: res_s = {{(DATA_WIDTH-1){1'b0}}, sub_s[DATA_WIDTH-1] ^ sub_ovf_s};
      4'b1000: res_s = A << shamt_s;
      4'b1001: res_s = A >> shamt_s;
      4'b1010: res_s = $unsigned($signed(A) >>> shamt_s);
      4'b1100: multi_s = 1'b1;
`ifdef ALU_SEQ_DIV_EN
      4'b1101: multi_s = 1'b1;
      4'b1110: multi_s = 1'b1;
`endif
      default: ill_s = 1'b1;
    endcase
  end

  // One multiply (shift-add) or divide (restoring) step on the held operands.
  always_comb begin
    it_acc_s = acc_r;
    it_a_s   = opa_r;
    it_b_s   = opb_r;
    if (op_r == 4'b1100) begin
      if (opb_r[0]) begin
        it_acc_s = acc_r + opa_r;
      end else begin
        it_acc_s = acc_r;
      end
      it_a_s = opa_r << 1;
      it_b_s = opb_r >> 1;
    end else begin
`ifdef ALU_SEQ_DIV_EN
      // acc holds the partial remainder, opa shifts dividend out / quotient in.
      if (rem_sh_s >= {1'b0, opb_r}) begin
        it_acc_s = diff_s[DATA_WIDTH-1:0];
        it_a_s   = {opa_r[DATA_WIDTH-2:0], 1'b1};
      end else begin
        it_acc_s = rem_sh_s[DATA_WIDTH-1:0];
        it_a_s   = {opa_r[DATA_WIDTH-2:0], 1'b0};
      end
`else
      it_acc_s = acc_r;
      it_a_s   = opa_r;
`endif
    end
  end

  // Final multi-cycle result: quotient for DIVU, accumulator otherwise.
  always_comb begin
    fin_res_s = it_acc_s;
`ifdef ALU_SEQ_DIV_EN
    if (op_r == 4'b1101) begin
      fin_res_s = it_a_s;
    end else begin
      fin_res_s = it_acc_s;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = multi_s ? CALC : DONE;
        else          state_nxt_s = IDLE;
      end
      CALC: begin
        if (cnt_r == CW'(1)) state_nxt_s = DONE;
        else                 state_nxt_s = CALC;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand capture, iteration registers and registered result/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= '0;
      op_r     <= 4'b0000;
      acc_r    <= '0;
      opa_r    <= '0;
      opb_r    <= '0;
      result_r <= '0;
      ovf_r    <= 1'b0;
      cry_r    <= 1'b0;
      zero_r   <= 1'b0;
      ill_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r  <= ALUop;
            cnt_r <= CW'(DATA_WIDTH);
            acc_r <= '0;
            opa_r <= A;
            opb_r <= B;
            ovf_r <= ovf_s;
            cry_r <= cry_s;
            ill_r <= ill_s;
            if (!multi_s) begin
              result_r <= res_s;
              zero_r   <= (res_s == '0);
            end
          end
        end
        CALC: begin
          acc_r <= it_acc_s;
          opa_r <= it_a_s;
          opb_r <= it_b_s;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            result_r <= fin_res_s;
            zero_r   <= (fin_res_s == '0);
          end
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, back-pressure and
// mid-operation reset sequences, then random operations against a model.
// Divide expectations follow ALU_SEQ_DIV_EN the same way the design does.
module tb_alu_seq;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a_in, b_in, result;
  logic [3:0]  alu_op;
  logic        overflow, carry_out, zero, illegal;

  int checks = 0;
  int errors = 0;

  alu_seq #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .ALUop(alu_op), .out_valid(out_valid), .out_ready(out_ready),
    .Result(result), .Overflow(overflow), .CarryOut(carry_out), .Zero(zero), .Illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        cry;
    logic        z;
    logic        ill;
    logic [7:0]  lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode definitions.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic o, output logic c,
                       output logic il, output int lat);
    longint sa, sb, s;
    longint unsigned ua;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'h0; o = 1'b0; c = 1'b0; il = 1'b0; lat = 1;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: begin
        ua = longint'(a) + longint'(b);
        r = ua[31:0]; c = (ua > 64'h0000_0000_FFFF_FFFF);
        s = sa + sb; o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h3: r = a ^ b;
      4'h4: r = ~(a | b);
      4'h5: r = (a < b) ? 32'd1 : 32'd0;
      4'h6: begin
        r = a - b; c = (a >= b);
        s = sa - sb; o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h8: r = a << b[4:0];
      4'h9: r = a >> b[4:0];
      4'hA: r = $unsigned($signed(a) >>> b[4:0]);
      4'hC: begin r = a * b; lat = 33; end
`ifdef ALU_SEQ_DIV_EN
      4'hD: begin r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b; lat = 33; end
      4'hE: begin r = (b == 32'h0) ? a : a % b; lat = 33; end
`endif
      default: il = 1'b1;
    endcase
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic ovf, input logic cry,
                              input logic ill, input logic [7:0] lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.ovf = ovf; v.cry = cry;
    v.z = (res == 32'h0); v.ill = ill; v.lat = lat;
    return v;
  endfunction

  // Issue one operation, measure latency from acceptance and check the result.
  task automatic run_op(input string nm, input vec_t v);
    int g, lat;
    logic busy_ok;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 200) begin @(negedge clk); g++; end
    chk({nm, "_ready"}, {63'h0, in_ready}, 64'h1);
    in_valid = 1'b1; a_in = v.a; b_in = v.b; alu_op = v.op;
    @(negedge clk);
    in_valid = 1'b0; a_in = $urandom; b_in = $urandom; alu_op = 4'($urandom);
    lat = 1; busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'(v.lat));
    chk({nm, "_busy"}, {63'h0, busy_ok}, 64'h1);
    chk({nm, "_res"}, {32'h0, result}, {32'h0, v.res});
    chk({nm, "_flags"}, {60'h0, overflow, carry_out, zero, illegal},
        {60'h0, v.ovf, v.cry, v.z, v.ill});
    chk({nm, "_inready_done"}, {63'h0, in_ready}, 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    logic o, c, il, bp_ok, stale;
    int lat;
    vec_t v;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_in = 32'h0; b_in = 32'h0; alu_op = 4'h0;
    #2;
    chk("reset_state", {57'h0, in_ready, out_valid, overflow, carry_out, zero, illegal, 1'b0},
        {57'h0, 1'b1, 6'h0});
    chk("reset_result", {32'h0, result}, 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back(mk(4'h2, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 8'd1));
    vecs.push_back(mk(4'h6, 32'h5, 32'h5, 32'h0, 1'b0, 1'b1, 1'b0, 8'd1));
    vecs.push_back(mk(4'h7, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0, 8'd1));
    vecs.push_back(mk(4'hA, 32'h8000_0000, 32'h1F, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 8'd1));
    vecs.push_back(mk(4'h5, 32'h8000_0000, 32'h1F, 32'h0, 1'b0, 1'b0, 1'b0, 8'd1));
    vecs.push_back(mk(4'hC, 32'hFFFF_FFFF, 32'h3, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 8'd33));
`ifdef ALU_SEQ_DIV_EN
    vecs.push_back(mk(4'hD, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 1'b0, 8'd33));
    vecs.push_back(mk(4'hD, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 8'd33));
    vecs.push_back(mk(4'hE, 32'd9, 32'd0, 32'd9, 1'b0, 1'b0, 1'b0, 8'd33));
    vecs.push_back(mk(4'hE, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 1'b0, 8'd33));
`else
    vecs.push_back(mk(4'hD, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 1'b1, 8'd1));
    vecs.push_back(mk(4'hD, 32'd9, 32'd0, 32'h0, 1'b0, 1'b0, 1'b1, 8'd1));
    vecs.push_back(mk(4'hE, 32'd9, 32'd0, 32'h0, 1'b0, 1'b0, 1'b1, 8'd1));
`endif
    vecs.push_back(mk(4'hB, 32'h1234, 32'h5678, 32'h0, 1'b0, 1'b0, 1'b1, 8'd1));
    vecs.push_back(mk(4'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0, 8'd1));
    vecs.push_back(mk(4'h4, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 8'd1));
    vecs.push_back(mk(4'h8, 32'h1, 32'h21, 32'h2, 1'b0, 1'b0, 1'b0, 8'd1));
    vecs.push_back(mk(4'h9, 32'h8000_0000, 32'h4, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 8'd1));
    vecs.push_back(mk(4'h6, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 8'd1));
    vecs.push_back(mk(4'h6, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 8'd1));
    vecs.push_back(mk(4'h2, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0, 8'd1));
    vecs.push_back(mk(4'h3, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 8'd1));
    vecs.push_back(mk(4'h1, 32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 1'b0, 1'b0, 1'b0, 8'd1));
    vecs.push_back(mk(4'hC, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0, 1'b0, 1'b0, 8'd33));
    vecs.push_back(mk(4'hF, 32'h1, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1, 8'd1));

    for (int i = 0; i < vecs.size(); i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-pressure: result must hold while out_ready stays low.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; a_in = 32'd1; b_in = 32'd2; alu_op = 4'h2;
    @(negedge clk);
    in_valid = 1'b0;
    bp_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_in = $urandom; b_in = $urandom;
      @(negedge clk);
      if (result !== 32'd3 || in_ready !== 1'b0 || out_valid !== 1'b1) bp_ok = 1'b0;
    end
    chk("bp_hold", {63'h0, bp_ok}, 64'h1);
    chk("bp_result", {32'h0, result}, 64'd3);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {62'h0, in_ready, out_valid}, 64'h2);

    // Reset in the middle of a multiply: immediate clear, no stale result.
    in_valid = 1'b1; a_in = 32'd5; b_in = 32'd6; alu_op = 4'hC;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {57'h0, in_ready, out_valid, overflow, carry_out, zero, illegal, 1'b0},
        {57'h0, 1'b1, 6'h0});
    chk("rst_mid_result", {32'h0, result}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    chk("rst_no_stale", {63'h0, stale}, 64'h0);

    // Random operations against the model.
    for (int i = 0; i < 150; i++) begin
      v.op = 4'($urandom_range(0, 15));
      v.a  = $urandom;
      v.b  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      model(v.op, v.a, v.b, r, o, c, il, lat);
      v.res = r; v.ovf = o; v.cry = c; v.ill = il; v.z = (r == 32'h0); v.lat = 8'(lat);
      run_op($sformatf("rnd%0d_op%0h", i, v.op), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational 32-bit ALU.
- Adds a valid/ready handshake, a wider 4-bit opcode set (XOR/NOR/SLTU/shifts) and an iterative shift-add multiplier.
- Iterative divide is an optional build feature.
- Sits between operand fetch and writeback in the multi-cycle CPU datapath; one operation in flight at a time.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits; must be >= 4 and a power of two.
- SHAMT_WIDTH, $clog2(DATA_WIDTH), width of shift amount taken from B[SHAMT_WIDTH-1:0].

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  block can accept an operation.
- A  input  DATA_WIDTH  operand A.
- B  input  DATA_WIDTH  operand B.
- ALUop  input  4  opcode.
- out_valid  output  1  Result/flags valid.
- out_ready  input  1  consumer accepts result.
- Result  output  DATA_WIDTH  registered result.
- Overflow  output  1  signed overflow (ADD/SUB only).
- CarryOut  output  1  carry out (ADD/SUB only).
- Zero  output  1  Result == 0.
- Illegal  output  1  opcode unsupported in this build.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low (rst_n).
- While rst_n=0: state IDLE; in_ready=1; out_valid=0; Result=0; Overflow=0; CarryOut=0; Zero=0; Illegal=0; internal counter/accumulators cleared.
- Reset mid-operation aborts the op; no result is produced.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SLTU, 0110 SUB, 0111 SLT.
  - 1000 SLL, 1001 SRL, 1010 SRA.
  - 1100 MUL: low DATA_WIDTH bits of the product.
  - 1101 DIVU, 1110 REMU (optional).
  - All others illegal.
- Handshake:
  - Operation accepted on a rising edge with in_valid && in_ready.
  - in_ready = (state==IDLE).
  - A/B/ALUop are captured at acceptance; later input changes are ignored.
  - Result/flags are stable while out_valid=1; they change only on acceptance of the next result.
- FSM states: IDLE, CALC, DONE.
  - IDLE --accept single-cycle op--> DONE. Result is visible the cycle after acceptance (latency 1).
  - IDLE --accept MUL/DIVU/REMU--> CALC; counter loaded with DATA_WIDTH.
  - CALC: one iteration per cycle; counter decrements; at counter==1 -> DONE.
  - Multi-cycle latency is exactly DATA_WIDTH+1 cycles from acceptance to out_valid.
  - DONE: out_valid=1; on out_ready -> IDLE. No bypass: in_ready=0 in DONE, so minimum two cycles per op.
  - out_ready is ignored outside DONE.
- Arithmetic (carry/overflow semantics unchanged from the combinational ALU):
  - ADD: {CarryOut,Result}=A+B; Overflow = sign(A)==sign(B) && sign(Result)!=sign(A).
  - SUB: {CarryOut,Result}=A+~B+1, so CarryOut=1 means no borrow; Overflow = sign(A)!=sign(B) && sign(Result)!=sign(A).
  - SLT: Result = {0..., signed A<B}, taken as the sign of (A-B) XOR the subtract overflow.
  - SLTU: Result = {0..., unsigned A<B}.
  - Overflow/CarryOut = 0 for all ops except ADD/SUB.
  - Shifts use B[SHAMT_WIDTH-1:0]; SRA replicates A[DATA_WIDTH-1].
  - MUL: shift-add over DATA_WIDTH iterations; result is modulo 2^DATA_WIDTH, identical for signed/unsigned.
  - Zero = (Result==0) for every op, registered with Result.
- Illegal opcode: latency 1, Result=0, Zero=1, Illegal=1, other flags 0. Illegal is cleared on the next acceptance.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined: 1101 DIVU and 1110 REMU are implemented.
  - Restoring unsigned division, one quotient bit per cycle, DATA_WIDTH+1 latency.
  - Divide by zero: DIVU Result = all ones; REMU Result = A. Same latency, Illegal=0.
- Undefined: 1101/1110 are treated as illegal opcodes; no divider logic is synthesised.

Test Plan:
- Reset then ADD A=0x7FFFFFFF, B=1 -> out_valid 1 cycle after accept; Result=0x80000000, Overflow=1, CarryOut=0, Zero=0.
- SUB A=5, B=5 then SLT A=0xFFFFFFFF, B=1 -> Result=0, Zero=1, CarryOut=1; then Result=1, Overflow=0.
- SRA A=0x80000000, B=0x1F -> Result=0xFFFFFFFF; SLTU with same operands -> Result=0.
- MUL A=0xFFFFFFFF, B=3 with out_ready=1 -> out_valid exactly 33 cycles after accept, Result=0xFFFFFFFD; in_ready=0 throughout.
- Back-pressure: out_ready=0 for 10 cycles in DONE while A/B toggle -> Result held, in_ready=0. rst_n pulsed low mid-MUL -> out_valid=0 and all outputs zero immediately; no stale result after release.
- DIVU A=100, B=7 and DIVU A=9, B=0 -> with ALU_SEQ_DIV_EN: 14 then 0xFFFFFFFF after 33 cycles each. Without the macro: Illegal=1, Result=0, latency 1.
